// File: rtl/usb_ctrl_pkg.sv
// Shared USB control-transfer definitions: request and descriptor codes,
// bmRequestType values and the EP0 responder state encoding.
package usb_ctrl_pkg;

   localparam logic [7:0] REQ_GET_DESCRIPTOR    = 8'h06;
   localparam logic [7:0] REQ_SET_ADDRESS       = 8'h05;
   localparam logic [7:0] REQ_SET_CONFIGURATION = 8'h09;

   localparam logic [7:0] DESC_DEVICE = 8'h01;
   localparam logic [7:0] DESC_CONFIG = 8'h02;

   localparam logic [7:0] RT_DEV_TO_HOST = 8'h80;
   localparam logic [7:0] RT_HOST_TO_DEV = 8'h00;

   typedef enum logic [2:0] {
      S_IDLE,
      S_COLLECT,
      S_DECODE,
      S_LOAD,
      S_WAIT_IN,
      S_ZLP,
      S_STATUS_OUT,
      S_STATUS_IN
   } ep0_state_t;

endpackage

// File: rtl/usb_ep0_ctrl_responder.sv
// EP0 control-request engine: collects the SETUP payload, streams descriptors
// from an external ROM in max-packet chunks and runs the status stages.
//
// state        | meaning
// S_IDLE       | no control transfer in progress
// S_COLLECT    | reading the 8 SETUP bytes from the receive queue
// S_DECODE     | one-cycle request decode
// S_LOAD       | copying one chunk from ROM into the send queue
// S_WAIT_IN    | waiting for the host to ACK the data packet
// S_ZLP        | zero-length IN terminating a short transfer
// S_STATUS_OUT | waiting for the host's zero-length OUT status
// S_STATUS_IN  | zero-length IN status, address applied on ACK
module usb_ep0_ctrl_responder
   import usb_ctrl_pkg::*;
#(
   parameter int MAX_PKT  = 8,
   parameter int ROM_AW   = 8,
   parameter int DEV_BASE = 0,
   parameter int DEV_LEN  = 18,
   parameter int CFG_BASE = 18,
   parameter int CFG_LEN  = 34
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_setup_start,
   input  logic              i_rq_empty,
   input  logic [7:0]        i_rq_data,
   output logic              o_rq_r_en,
   input  logic              i_sq_empty,
   output logic [7:0]        o_sq_data,
   output logic              o_sq_w_en,
   input  logic              i_in_done,
   input  logic              i_out_done,
   output logic [ROM_AW-1:0] o_rom_addr,
   input  logic [7:0]        i_rom_data,
   output logic              o_data_toggle,
   output logic              o_stall,
   output logic [6:0]        o_usb_addr,
   output logic              o_busy
);

   localparam logic [15:0]       MAX16      = 16'(MAX_PKT);
   localparam logic [6:0]        MAX7       = 7'(MAX_PKT);
   localparam logic [15:0]       DEV_LEN16  = 16'(DEV_LEN);
   localparam logic [15:0]       CFG_LEN16  = 16'(CFG_LEN);
   localparam logic [ROM_AW-1:0] DEV_BASE_A = ROM_AW'(DEV_BASE);
   localparam logic [ROM_AW-1:0] CFG_BASE_A = ROM_AW'(CFG_BASE);

   ep0_state_t        r_state;
   logic [3:0]        r_rd_cnt;
   logic [2:0]        r_cap_cnt;
   logic              r_rd_pend;
   logic [7:0]        r_bmreq;
   logic [7:0]        r_breq;
   logic [6:0]        r_wval_lo;
   logic [7:0]        r_wval_hi;
   logic [15:0]       r_wlen;
   logic [ROM_AW-1:0] r_base;
   logic [ROM_AW-1:0] r_offset;
   logic [15:0]       r_remain;
   logic [6:0]        r_chunk;
   logic              r_short;
   logic              r_active;
   logic [6:0]        r_addr_cnt;
   logic              r_addr_vld;
   logic [6:0]        r_wr_cnt;
   logic              r_sq_w_en;
   logic [ROM_AW-1:0] r_rom_addr;
   logic              r_toggle;
   logic              r_stall;
   logic [6:0]        r_usb_addr;
   logic [6:0]        r_pend_addr;
   logic              r_set_addr;

   logic              w_rq_r_en;
   logic              w_desc_dev;
   logic              w_desc_cfg;
   logic [15:0]       w_desc_len;
   logic [ROM_AW-1:0] w_desc_base;
   logic [15:0]       w_desc_rem;
   logic [6:0]        w_chunk;
   logic [15:0]       w_rem_next;

   // A fresh SETUP blocks the read so no byte is popped into a discarded collect.
   assign w_rq_r_en = (r_state == S_COLLECT) && !i_setup_start && !i_rq_empty &&
                      (r_rd_cnt < 4'd8);

   always_comb begin
      w_desc_dev  = (r_bmreq == RT_DEV_TO_HOST) && (r_breq == REQ_GET_DESCRIPTOR) &&
                    (r_wval_hi == DESC_DEVICE);
      w_desc_cfg  = (r_bmreq == RT_DEV_TO_HOST) && (r_breq == REQ_GET_DESCRIPTOR) &&
                    (r_wval_hi == DESC_CONFIG);
      w_desc_len  = w_desc_dev ? DEV_LEN16 : CFG_LEN16;
      w_desc_base = w_desc_dev ? DEV_BASE_A : CFG_BASE_A;
      w_desc_rem  = (r_wlen < w_desc_len) ? r_wlen : w_desc_len;
      w_chunk     = (r_remain < MAX16) ? r_remain[6:0] : MAX7;
      w_rem_next  = r_remain - 16'(r_chunk);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_rd_cnt    <= '0;
         r_cap_cnt   <= '0;
         r_rd_pend   <= 1'b0;
         r_bmreq     <= '0;
         r_breq      <= '0;
         r_wval_lo   <= '0;
         r_wval_hi   <= '0;
         r_wlen      <= '0;
         r_base      <= '0;
         r_offset    <= '0;
         r_remain    <= '0;
         r_chunk     <= '0;
         r_short     <= 1'b0;
         r_active    <= 1'b0;
         r_addr_cnt  <= '0;
         r_addr_vld  <= 1'b0;
         r_wr_cnt    <= '0;
         r_sq_w_en   <= 1'b0;
         r_rom_addr  <= '0;
         r_toggle    <= 1'b0;
         r_stall     <= 1'b0;
         r_usb_addr  <= '0;
         r_pend_addr <= '0;
         r_set_addr  <= 1'b0;
      end else begin
         r_sq_w_en  <= 1'b0;
         r_addr_vld <= 1'b0;
         if (i_setup_start) begin
            r_state    <= S_COLLECT;
            r_rd_cnt   <= '0;
            r_cap_cnt  <= '0;
            r_rd_pend  <= 1'b0;
            r_stall    <= 1'b0;
            r_set_addr <= 1'b0;
            r_active   <= 1'b0;
         end else begin
            case (r_state)
               S_COLLECT: begin
                  r_rd_pend <= w_rq_r_en;
                  if (w_rq_r_en) r_rd_cnt <= r_rd_cnt + 4'd1;
                  if (r_rd_pend) begin
                     case (r_cap_cnt)
                        3'd0: r_bmreq <= i_rq_data;
                        3'd1: r_breq <= i_rq_data;
                        3'd2: r_wval_lo <= i_rq_data[6:0];
                        3'd3: r_wval_hi <= i_rq_data;
                        3'd6: r_wlen[7:0] <= i_rq_data;
                        3'd7: r_wlen[15:8] <= i_rq_data;
                        default: ;
                     endcase
                     r_cap_cnt <= r_cap_cnt + 3'd1;
                     if (r_cap_cnt == 3'd7) r_state <= S_DECODE;
                  end
               end
               S_DECODE: begin
                  if (w_desc_dev || w_desc_cfg) begin
                     r_base   <= w_desc_base;
                     r_offset <= '0;
                     r_remain <= w_desc_rem;
                     r_short  <= (w_desc_len < r_wlen);
                     r_toggle <= 1'b1;
                     r_state  <= (w_desc_rem == 16'd0) ? S_STATUS_OUT : S_LOAD;
                  end else if ((r_bmreq == RT_HOST_TO_DEV) && (r_breq == REQ_SET_ADDRESS)) begin
                     r_pend_addr <= r_wval_lo;
                     r_set_addr  <= 1'b1;
                     r_toggle    <= 1'b1;
                     r_state     <= S_STATUS_IN;
                  end else if ((r_bmreq == RT_HOST_TO_DEV) &&
                               (r_breq == REQ_SET_CONFIGURATION)) begin
                     r_toggle <= 1'b1;
                     r_state  <= S_STATUS_IN;
                  end else begin
                     r_stall <= 1'b1;
                     r_state <= S_IDLE;
                  end
               end
               S_LOAD: begin
                  // Address leads the queue write by one cycle to cover ROM latency.
                  if (!r_active) begin
                     if (i_sq_empty) begin
                        r_chunk    <= w_chunk;
                        r_rom_addr <= r_base + r_offset;
                        r_addr_vld <= 1'b1;
                        r_addr_cnt <= 7'd1;
                        r_wr_cnt   <= '0;
                        r_active   <= 1'b1;
                     end
                  end else begin
                     if (r_addr_cnt < r_chunk) begin
                        r_rom_addr <= r_rom_addr + 1'b1;
                        r_addr_vld <= 1'b1;
                        r_addr_cnt <= r_addr_cnt + 7'd1;
                     end
                     r_sq_w_en <= r_addr_vld;
                     if (r_sq_w_en) begin
                        if (r_wr_cnt == (r_chunk - 7'd1)) begin
                           r_active <= 1'b0;
                           r_state  <= S_WAIT_IN;
                        end else begin
                           r_wr_cnt <= r_wr_cnt + 7'd1;
                        end
                     end
                  end
               end
               S_WAIT_IN: begin
                  if (i_in_done) begin
                     r_offset <= r_offset + ROM_AW'(r_chunk);
                     r_remain <= w_rem_next;
                     if (w_rem_next != 16'd0) begin
                        r_toggle <= ~r_toggle;
                        r_state  <= S_LOAD;
                     end else if ((r_chunk == MAX7) && r_short) begin
                        r_toggle <= ~r_toggle;
                        r_state  <= S_ZLP;
                     end else begin
                        r_toggle <= 1'b1;
                        r_state  <= S_STATUS_OUT;
                     end
                  end
               end
               S_ZLP: begin
                  if (i_in_done) begin
                     r_toggle <= 1'b1;
                     r_state  <= S_STATUS_OUT;
                  end
               end
               S_STATUS_OUT: begin
                  if (i_out_done) r_state <= S_IDLE;
               end
               S_STATUS_IN: begin
                  if (i_in_done) begin
                     if (r_set_addr) r_usb_addr <= r_pend_addr;
                     r_set_addr <= 1'b0;
                     r_state    <= S_IDLE;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign o_rq_r_en     = w_rq_r_en;
   assign o_sq_w_en     = r_sq_w_en;
   assign o_sq_data     = r_sq_w_en ? i_rom_data : 8'h00;
   assign o_rom_addr    = r_rom_addr;
   assign o_data_toggle = r_toggle;
   assign o_stall       = r_stall;
   assign o_usb_addr    = r_usb_addr;
   assign o_busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_usb_ep0_ctrl_responder.sv
// Scoreboard bench for the EP0 responder: a host-side driver queues expected
// IN bytes and toggles, a monitor checks every send-queue write against them.
module tb_usb_ep0_ctrl_responder;

   localparam int ROM_AW = 8;

   logic              clk;
   logic              rst;
   logic              setup_start;
   logic              rq_empty;
   logic [7:0]        rq_data;
   logic              rq_r_en;
   logic              sq_empty;
   logic [7:0]        sq_data;
   logic              sq_w_en;
   logic              in_done;
   logic              out_done;
   logic [ROM_AW-1:0] rom_addr;
   logic [7:0]        rom_data;
   logic              data_toggle;
   logic              stall;
   logic [6:0]        usb_addr;
   logic              busy;

   typedef struct packed {
      logic [7:0] data;
      logic       tog;
   } exp_t;

   exp_t       exp_q[$];
   int         n_checks = 0;
   int         n_fail = 0;
   int         n_wr = 0;
   logic [7:0] rq_mem[256];
   int         rq_rd = 0;
   int         rq_wr = 0;

   usb_ep0_ctrl_responder #(
      .MAX_PKT(8), .ROM_AW(ROM_AW), .DEV_BASE(0), .DEV_LEN(18),
      .CFG_BASE(18), .CFG_LEN(32)
   ) dut (
      .clk(clk), .rst(rst),
      .i_setup_start(setup_start),
      .i_rq_empty(rq_empty), .i_rq_data(rq_data), .o_rq_r_en(rq_r_en),
      .i_sq_empty(sq_empty), .o_sq_data(sq_data), .o_sq_w_en(sq_w_en),
      .i_in_done(in_done), .i_out_done(out_done),
      .o_rom_addr(rom_addr), .i_rom_data(rom_data),
      .o_data_toggle(data_toggle), .o_stall(stall),
      .o_usb_addr(usb_addr), .o_busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] rom_val(input int a);
      return 8'((a * 37 + 11) & 255);
   endfunction

   always @(posedge clk) rom_data <= rom_val(int'(rom_addr));

   assign rq_empty = (rq_rd == rq_wr);
   always @(posedge clk) begin
      if (rq_r_en) begin
         rq_data <= rq_mem[rq_rd & 255];
         rq_rd   <= rq_rd + 1;
      end
   end

   always @(negedge clk) begin
      if (rst === 1'b1 && sq_w_en === 1'b1) begin
         n_wr++;
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_write: got data %02h toggle %0b, required no write",
                     sq_data, data_toggle);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (sq_data !== e.data || data_toggle !== e.tog) begin
               n_fail++;
               $display("FAIL in_byte: got data %02h toggle %0b, required data %02h toggle %0b",
                        sq_data, data_toggle, e.data, e.tog);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic expect_pkt(input int start, input int n, input logic tog);
      for (int i = 0; i < n; i++) exp_q.push_back('{data: rom_val(start + i), tog: tog});
   endtask

   task automatic load_setup(input logic [63:0] pkt);
      for (int i = 0; i < 8; i++) rq_mem[(rq_wr + i) & 255] = pkt[8*i +: 8];
      rq_wr = rq_wr + 8;
   endtask

   task automatic send_setup(input logic [63:0] pkt);
      @(negedge clk);
      load_setup(pkt);
      setup_start = 1'b1;
      @(negedge clk);
      setup_start = 1'b0;
   endtask

   task automatic wait_cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic pulse_in;
      @(negedge clk);
      in_done = 1'b1;
      @(negedge clk);
      in_done = 1'b0;
   endtask

   task automatic pulse_out;
      @(negedge clk);
      out_done = 1'b1;
      @(negedge clk);
      out_done = 1'b0;
   endtask

   // Wait until the monitor has consumed every queued byte, then ACK the packet.
   task automatic serve_in(input string name);
      int t = 0;
      while (exp_q.size() != 0 && t < 300) begin
         @(posedge clk);
         t++;
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s: got %0d bytes still outstanding, required 0", name, exp_q.size());
         exp_q.delete();
      end
      wait_cycles(3);
      pulse_in();
   endtask

   initial begin
      int t;
      int wr0;
      rst = 1'b0;
      setup_start = 1'b0;
      sq_empty = 1'b1;
      in_done = 1'b0;
      out_done = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("rst_rq_r_en", 32'(rq_r_en), 0);
      chk("rst_sq_w_en", 32'(sq_w_en), 0);
      chk("rst_sq_data", 32'(sq_data), 0);
      chk("rst_rom_addr", 32'(rom_addr), 0);
      chk("rst_toggle", 32'(data_toggle), 0);
      chk("rst_stall", 32'(stall), 0);
      chk("rst_usb_addr", 32'(usb_addr), 0);
      chk("rst_busy", 32'(busy), 0);
      rst = 1'b1;
      wait_cycles(2);

      // GET_DESCRIPTOR device, wLength 0x40: 8+8+2 bytes, toggles 1,0,1
      expect_pkt(0, 8, 1'b1);
      send_setup(64'h0040_0000_0100_0680);
      chk("dev_busy", 32'(busy), 1);
      serve_in("dev_pkt0");
      expect_pkt(8, 8, 1'b0);
      serve_in("dev_pkt1");
      expect_pkt(16, 2, 1'b1);
      serve_in("dev_pkt2");
      wait_cycles(4);
      chk("dev_status_toggle", 32'(data_toggle), 1);
      chk("dev_status_busy", 32'(busy), 1);
      pulse_out();
      chk("dev_idle", 32'(busy), 0);

      // GET_DESCRIPTOR config, wLength 9, send queue initially full
      sq_empty = 1'b0;
      expect_pkt(18, 8, 1'b1);
      send_setup(64'h0009_0000_0200_0680);
      wr0 = n_wr;
      wait_cycles(30);
      chk("cfg9_hold_when_full", 32'(n_wr - wr0), 0);
      sq_empty = 1'b1;
      serve_in("cfg9_pkt0");
      expect_pkt(26, 1, 1'b0);
      serve_in("cfg9_pkt1");
      wait_cycles(4);
      chk("cfg9_status_toggle", 32'(data_toggle), 1);
      pulse_out();
      chk("cfg9_idle", 32'(busy), 0);

      // GET_DESCRIPTOR config, wLength 0xFF, 32-byte set: 4 full packets then ZLP
      expect_pkt(18, 8, 1'b1);
      send_setup(64'h00FF_0000_0200_0680);
      serve_in("cfgzlp_pkt0");
      expect_pkt(26, 8, 1'b0);
      serve_in("cfgzlp_pkt1");
      expect_pkt(34, 8, 1'b1);
      serve_in("cfgzlp_pkt2");
      expect_pkt(42, 8, 1'b0);
      serve_in("cfgzlp_pkt3");
      wait_cycles(5);
      chk("zlp_toggle", 32'(data_toggle), 1);
      pulse_out();
      chk("zlp_ignores_out_done", 32'(busy), 1);
      pulse_in();
      chk("zlp_done_toggle", 32'(data_toggle), 1);
      chk("zlp_status_busy", 32'(busy), 1);
      pulse_out();
      chk("zlp_idle", 32'(busy), 0);

      // SET_ADDRESS 0x23
      send_setup(64'h0000_0000_0023_0500);
      wait_cycles(20);
      chk("setaddr_pre_addr", 32'(usb_addr), 0);
      chk("setaddr_busy", 32'(busy), 1);
      chk("setaddr_toggle", 32'(data_toggle), 1);
      pulse_in();
      chk("setaddr_addr", 32'(usb_addr), 32'h23);
      chk("setaddr_idle", 32'(busy), 0);

      // Unsupported request 0x80/0x00
      send_setup(64'h0002_0000_0000_0080);
      wait_cycles(20);
      chk("unsup_stall", 32'(stall), 1);
      chk("unsup_idle", 32'(busy), 0);

      // New SETUP mid-LOAD: old chunk abandoned, SET_CONFIGURATION handled cleanly
      expect_pkt(0, 8, 1'b1);
      wr0 = n_wr;
      send_setup(64'h0040_0000_0100_0680);
      chk("abort_stall_cleared", 32'(stall), 0);
      t = 0;
      while ((n_wr - wr0) < 3 && t < 300) begin
         @(posedge clk);
         t++;
      end
      chk("abort_reached_load", 32'((n_wr - wr0) >= 3), 1);
      @(negedge clk);
      load_setup(64'h0000_0000_0001_0900);
      setup_start = 1'b1;
      @(posedge clk);
      #1;
      exp_q.delete();
      setup_start = 1'b0;
      chk("abort_partial_chunk", 32'((n_wr - wr0) < 8), 1);
      wait_cycles(20);
      chk("abort_collect_done", 32'(rq_rd == rq_wr), 1);
      chk("abort_busy", 32'(busy), 1);
      chk("abort_toggle", 32'(data_toggle), 1);
      pulse_in();
      chk("abort_idle", 32'(busy), 0);
      chk("abort_addr_kept", 32'(usb_addr), 32'h23);

      wait_cycles(5);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required test completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/usb_ep0_ctrl_responder.md
Name: usb_ep0_ctrl_responder

Overview:
- EP0 control-request engine between the USB receive queue (8-byte SETUP payload) and the USB send queue (IN data packets).
- Parses the setup packet, answers GET_DESCRIPTOR from an external descriptor ROM in max-packet chunks, and handles SET_ADDRESS / SET_CONFIGURATION status stages.
- Owns the EP0 data toggle and the device address register consumed by the USB core.

Parameters:
- MAX_PKT, 8: EP0 max packet size in bytes (8..64).
- ROM_AW, 8: descriptor ROM address width.
- DEV_BASE, 0: ROM offset of the device descriptor.
- DEV_LEN, 18: device descriptor length.
- CFG_BASE, 18: ROM offset of the configuration descriptor set.
- CFG_LEN, 34: total configuration descriptor length.

Ports:
- clk  in  1  system clock (48 MHz).
- rst  in  1  synchronous reset, active-low.
- setup_start  in  1  pulse: SETUP token on EP0 accepted; 8 payload bytes follow in the receive queue.
- rq_empty  in  1  receive queue empty.
- rq_data  in  8  receive queue read data; valid the cycle after rq_r_en.
- rq_r_en  out  1  receive queue read strobe.
- sq_empty  in  1  send queue empty.
- sq_data  out  8  send queue write data.
- sq_w_en  out  1  send queue write strobe.
- in_done  in  1  pulse: IN data packet ACKed by host.
- out_done  in  1  pulse: zero-length OUT status stage completed.
- rom_addr  out  ROM_AW  descriptor ROM address.
- rom_data  in  8  ROM data, one-cycle latency.
- data_toggle  out  1  DATA0/DATA1 for the next EP0 IN packet.
- stall  out  1  respond STALL to EP0 data/status stage.
- usb_addr  out  7  current device address.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0 at a clk edge): state IDLE. All outputs 0, including usb_addr, data_toggle and stall. Internal counters cleared.
- States: IDLE, COLLECT, DECODE, LOAD, WAIT_IN, ZLP, STATUS_OUT, STATUS_IN.
- setup_start has priority over every state except reset:
  - enter COLLECT, byte count = 0, stall = 0, pending address discarded;
  - any in-flight chunk is abandoned.
- COLLECT:
  - assert rq_r_en for one cycle whenever !rq_empty and fewer than 8 reads have been issued;
  - capture rq_data one cycle later;
  - byte 0 = bmRequestType, 1 = bRequest, 2-3 wValue, 4-5 wIndex, 6-7 wLength (all little-endian);
  - after the 8th capture, go to DECODE.
- DECODE (exactly 1 cycle):
  - 0x80/0x06, wValue[15:8]=1: base=DEV_BASE, remaining=min(wLength, DEV_LEN).
  - 0x80/0x06, wValue[15:8]=2: base=CFG_BASE, remaining=min(wLength, CFG_LEN).
  - For either GET_DESCRIPTOR case: set short=(descriptor length < wLength); data_toggle=1; go to LOAD, or STATUS_OUT if remaining=0.
  - 0x00/0x05: pend_addr=wValue[6:0]; data_toggle=1; go to STATUS_IN.
  - 0x00/0x09: data_toggle=1; go to STATUS_IN.
  - Anything else: stall=1; go to IDLE.
- LOAD:
  - wait for sq_empty=1;
  - chunk=min(remaining, MAX_PKT);
  - issue rom_addr=base+offset on cycle k, write sq_data=rom_data with sq_w_en=1 on cycle k+1;
  - back-to-back one byte per cycle, exactly chunk writes;
  - go to WAIT_IN after the last write.
- WAIT_IN, on in_done:
  - data_toggle flips; offset += chunk; remaining -= chunk.
  - If remaining>0: go to LOAD.
  - If remaining=0 and chunk=MAX_PKT and short=1: go to ZLP.
  - Otherwise: data_toggle=1 and go to STATUS_OUT.
- ZLP: nothing written; on in_done set data_toggle=1 and go to STATUS_OUT.
- STATUS_OUT: on out_done go to IDLE.
- STATUS_IN:
  - zero-length IN, no queue write;
  - on in_done: usb_addr<=pend_addr if SET_ADDRESS, then go to IDLE.
  - usb_addr never changes before that in_done.
- Arithmetic: remaining is 16-bit unsigned; offset is ROM_AW bits; rom_addr wraps modulo 2^ROM_AW.
- Ignored inputs: in_done/out_done outside their waiting states; rq_data when no read is outstanding.
- Simultaneous in_done and setup_start: setup_start wins, toggle is not flipped.
- stall holds until the next setup_start or reset.

Decomposition:
- Shared package usb_ctrl_pkg holds:
  - request codes (GET_DESCRIPTOR=6, SET_ADDRESS=5, SET_CONFIGURATION=9);
  - descriptor type codes (DEVICE=1, CONFIG=2);
  - bmRequestType constants;
  - state encoding.
- Natural sub-module: usb_desc_rom, a synchronous ROM with 1-cycle latency initialised from a hex file. It is instantiated beside this block, not inside it.

Test Plan:
- Reset: rst=0 for 2 cycles → all outputs 0, busy=0, usb_addr=0.
- GET_DESCRIPTOR device, wLength=0x40:
  - packets of 8, 8, 2 bytes matching ROM[0..17];
  - data_toggle 1, 0, 1 per packet;
  - no ZLP;
  - out_done → IDLE.
- GET_DESCRIPTOR config, wLength=0x0009 → single 8-byte chunk then 1-byte chunk, nothing beyond ROM[26].
- GET_DESCRIPTOR config with CFG_LEN=32 and wLength=0xFF → four 8-byte packets then a ZLP awaiting in_done, then STATUS_OUT.
- SET_ADDRESS wValue=0x0023:
  - no sq_w_en;
  - usb_addr stays 0 until in_done;
  - usb_addr=0x23 the cycle after in_done.
- Unsupported 0x80/0x00 → stall=1, IDLE. New setup_start mid-LOAD of a prior request → stall=0, fresh 8-byte collect, old chunk abandoned.
